jstkpoll: RTL and testbench
===========================

# jstkpoll

Periodic poll controller sitting directly upstream of the SPI joystick interface. It raises the joystick's request line at a fixed rate and waits for the joystick's one-cycle data-valid strobe. It then latches the 10-bit X/Y and 3-bit button data and publishes them, together with a deadzone-filtered direction vector and button-press pulses, to the application logic. It also drives the joystick LED bits and flags transactions that never complete.

## Interface
- POLLDIV, 50000: clock cycles between poll starts; legal range ≥ 2.
- TIMEOUT, 4096: maximum cycles in REQ before abort; legal range ≥ 2.
- CENTER, 512: joystick rest value, 10-bit.
- DEADZONE, 64: half-width of the no-direction band; CENTER−DEADZONE ≥ 0 and CENTER+DEADZONE ≤ 1023.

Ports:
- jstkclk  in  1  system clock.
- jstkreset  in  1  reset; asynchronous, active-high.
- pollen  in  1  polling enable.
- ledreq  in  2  requested joystick LED state.
- errclr  in  1  clears pollerr.
- jstkdav  out  1  request to joystick; high for the whole transaction.
- jstkled  out  2  LED bits to joystick; stable while jstkdav is high.
- davjstk  in  1  joystick done strobe; one cycle.
- jstkxdata  in  10  X from joystick; valid when davjstk is high.
- jstkydata  in  10  Y from joystick; valid when davjstk is high.
- jstkbutton  in  3  buttons from joystick; valid when davjstk is high.
- posx  out  10  latched X.
- posy  out  10  latched Y.
- buttons  out  3  latched buttons.
- dir  out  4  {up, down, left, right}.
- btnpress  out  3  rising-edge pulse per button.
- davpoll  out  1  new-sample strobe; one cycle.
- pollerr  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: jstkdav=0. The poll counter increments each cycle while pollen=1 and is held at 0 while pollen=0. When the counter reaches POLLDIV−1: counter→0, jstkled←ledreq, go to REQ.
  - REQ: jstkdav=1. The timeout counter increments each cycle.
    - davjstk=1: capture (below), go to IDLE.
    - davjstk=0 and the timeout counter reaches TIMEOUT−1: pollerr←1, go to IDLE. No capture, no davpoll.
- Capture, all in one edge:
  - posx, posy, buttons ← inputs.
  - btnpress ← jstkbutton & ~buttons(old).
  - dir updated from the new X/Y values.
  - davpoll←1.
- Direction rule (compare in 11-bit unsigned arithmetic):
  - right = X > CENTER+DEADZONE; left = X < CENTER−DEADZONE.
  - up = Y > CENTER+DEADZONE; down = Y < CENTER−DEADZONE.
  - Values exactly on a boundary produce no direction.
- Dropping pollen during REQ does not abort the transaction; it completes normally, then the block stays in IDLE.
- davjstk seen while in IDLE is ignored.
- davjstk and timeout on the same cycle: davjstk wins (capture, no error).
- errclr and a new timeout on the same cycle: set wins.
- errclr has no effect on any other state.

## Timing
- Reset values: jstkdav=0, jstkled=0, posx=posy=0, buttons=0, dir=0, btnpress=0, davpoll=0, pollerr=0; state IDLE, both counters 0.
- Reset asserted mid-REQ drops jstkdav asynchronously, which also restarts the joystick.
- Latency: davpoll, btnpress and all captured outputs update on the edge that samples davjstk=1, so they are visible one cycle after davjstk.
- davpoll and btnpress are high for exactly one cycle.
- jstkdav is low for at least one full cycle between transactions, so the joystick returns to its idle state.
- Poll period with pollen held high: POLLDIV IDLE cycles plus the REQ duration.
- First REQ after reset or pollen rising: POLLDIV cycles later.
- Timeout: jstkdav falls TIMEOUT cycles after it rose; pollerr is visible on the same edge.

## Structure
- Package jstkpoll_pkg holds:
  - state encoding (IDLE, REQ);
  - dir bit indices (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0);
  - default CENTER and DEADZONE constants.
- Sub-module jstkdeadzone: combinational classifier taking a 10-bit value, CENTER and DEADZONE, returning {hi, lo}. It is instantiated twice (X→{right, left}, Y→{up, down}) and its outputs are registered in jstkpoll on capture.

## Test plan
Bench parameters: POLLDIV=16, TIMEOUT=32, CENTER=512, DEADZONE=64.
- Normal poll: pollen=1, ledreq=2'b10; the joystick model answers 10 cycles after jstkdav rises with X=700, Y=300, buttons=3'b001 → jstkdav rises 16 cycles after reset release, jstkled=2'b10; one cycle after davjstk: posx=700, posy=300, dir=4'b0101, btnpress=3'b001, davpoll high for exactly 1 cycle, jstkdav low.
- Deadzone boundaries: X=576, Y=448 → dir=0. X=577, Y=447 → dir=4'b0101.
- Button edges: consecutive samples with buttons 3'b011, then 3'b011, then 3'b110 → btnpress=3'b011, then 3'b000, then 3'b100.
- Timeout: model never answers → jstkdav high for 32 cycles then low; pollerr=1, posx unchanged, no davpoll. errclr pulse → pollerr=0. davjstk on cycle 32 → capture, pollerr stays 0.
- pollen dropped 3 cycles into REQ → transaction completes with davpoll; no further jstkdav rise while pollen=0.
- Reset mid-REQ → jstkdav=0 immediately, all outputs at reset values; the next REQ follows 16 cycles after release.

Source files
------------

// File: rtl/jstkpoll_pkg.sv
// jstkpoll_pkg
//   Shared definitions for the joystick poll controller:
//   - controller state encoding
//   - bit positions inside the {up, down, left, right} direction vector
//   - default rest value and deadzone half-width for a 10-bit joystick axis
package jstkpoll_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int DEFAULT_CENTER   = 512;
    localparam int DEFAULT_DEADZONE = 64;

endpackage

// File: rtl/jstkpoll_deadzone.sv
// jstkdeadzone
//   Combinational axis classifier. Reports whether a 10-bit axis value lies
//   strictly above or strictly below the band [center-deadzone, center+deadzone].
//   Values on the band edges report neither.
// Ports:
//   value     in  10  axis sample
//   center    in  10  rest value
//   deadzone  in  10  half-width of the no-direction band
//   hi        out 1   value > center + deadzone
//   lo        out 1   value < center - deadzone
module jstkdeadzone
    import jstkpoll_pkg::*;
(
    input  logic [9:0] value,
    input  logic [9:0] center,
    input  logic [9:0] deadzone,
    output logic       hi,
    output logic       lo
);

    logic [10:0] value_ext;
    logic [10:0] hi_limit;
    logic [10:0] lo_limit;

    // 11-bit compare so center+deadzone cannot wrap
    always_comb begin
        value_ext = {1'b0, value};
        hi_limit  = {1'b0, center} + {1'b0, deadzone};
        lo_limit  = {1'b0, center} - {1'b0, deadzone};
        hi        = (value_ext > hi_limit);
        lo        = (value_ext < lo_limit);
    end

endmodule

// File: rtl/jstkpoll.sv
// jstkpoll
//   Periodic poll controller in front of the SPI joystick interface. While
//   pollen is high it raises jstkdav every POLLDIV idle cycles, holds it for the
//   whole transaction, and latches X/Y/buttons on the joystick's davjstk strobe.
//   On capture it publishes a deadzone-filtered direction vector, button-press
//   pulses and a one-cycle davpoll strobe. A transaction that runs TIMEOUT
//   cycles without davjstk is abandoned and flagged on the sticky pollerr.
// Ports:
//   jstkclk     in  1   system clock
//   jstkreset   in  1   asynchronous active-high reset
//   pollen      in  1   polling enable
//   ledreq      in  2   requested LED state, sampled at transaction start
//   errclr      in  1   clears pollerr (a same-cycle timeout wins)
//   jstkdav     out 1   request to joystick, high for the whole transaction
//   jstkled     out 2   LED bits to joystick
//   davjstk     in  1   joystick done strobe
//   jstkxdata   in  10  X sample
//   jstkydata   in  10  Y sample
//   jstkbutton  in  3   button sample
//   posx/posy   out 10  latched X/Y
//   buttons     out 3   latched buttons
//   dir         out 4   {up, down, left, right}
//   btnpress    out 3   one-cycle rising-edge pulse per button
//   davpoll     out 1   one-cycle new-sample strobe
//   pollerr     out 1   sticky timeout flag
module jstkpoll
    import jstkpoll_pkg::*;
#(
    parameter int POLLDIV  = 50000,
    parameter int TIMEOUT  = 4096,
    parameter int CENTER   = DEFAULT_CENTER,
    parameter int DEADZONE = DEFAULT_DEADZONE
) (
    input  logic        jstkclk,
    input  logic        jstkreset,
    input  logic        pollen,
    input  logic [1:0]  ledreq,
    input  logic        errclr,
    output logic        jstkdav,
    output logic [1:0]  jstkled,
    input  logic        davjstk,
    input  logic [9:0]  jstkxdata,
    input  logic [9:0]  jstkydata,
    input  logic [2:0]  jstkbutton,
    output logic [9:0]  posx,
    output logic [9:0]  posy,
    output logic [2:0]  buttons,
    output logic [3:0]  dir,
    output logic [2:0]  btnpress,
    output logic        davpoll,
    output logic        pollerr
);

    localparam int PW = (POLLDIV > 2) ? $clog2(POLLDIV) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLLDIV - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [9:0]    CENTER_V   = 10'(CENTER);
    localparam logic [9:0]    DEADZONE_V = 10'(DEADZONE);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            start;
    logic            capture;
    logic            expire;
    logic            x_hi;
    logic            x_lo;
    logic            y_hi;
    logic            y_lo;
    logic [3:0]      dir_new;

    jstkdeadzone u_dz_x (
        .value    (jstkxdata),
        .center   (CENTER_V),
        .deadzone (DEADZONE_V),
        .hi       (x_hi),
        .lo       (x_lo)
    );

    jstkdeadzone u_dz_y (
        .value    (jstkydata),
        .center   (CENTER_V),
        .deadzone (DEADZONE_V),
        .hi       (y_hi),
        .lo       (y_lo)
    );

    // Next-state decode and the one-cycle start/capture/expire events
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                // davjstk is ignored here
                if (pollen && (poll_cnt == POLL_LAST)) begin
                    start      = 1'b1;
                    state_next = ST_REQ;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                // a strobe on the final timeout cycle still counts as a capture
                if (davjstk) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    expire     = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Direction vector from the incoming sample
    always_comb begin
        dir_new            = 4'b0000;
        dir_new[DIR_UP]    = y_hi;
        dir_new[DIR_DOWN]  = y_lo;
        dir_new[DIR_LEFT]  = x_lo;
        dir_new[DIR_RIGHT] = x_hi;
    end

    // State register; jstkdav is a flop copy of the REQ state
    always_ff @(posedge jstkclk or posedge jstkreset) begin
        if (jstkreset) begin
            state   <= ST_IDLE;
            jstkdav <= 1'b0;
        end else begin
            state   <= state_next;
            jstkdav <= (state_next == ST_REQ);
        end
    end

    // Poll and timeout counters; each runs only in its own state
    always_ff @(posedge jstkclk or posedge jstkreset) begin
        if (jstkreset) begin
            poll_cnt <= {PW{1'b0}};
            tmo_cnt  <= {TW{1'b0}};
        end else begin
            if ((state == ST_IDLE) && pollen && !start) begin
                poll_cnt <= poll_cnt + PW'(1);
            end else begin
                poll_cnt <= {PW{1'b0}};
            end
            if ((state == ST_REQ) && (state_next == ST_REQ)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= {TW{1'b0}};
            end
        end
    end

    // LED latch, sample capture, strobes and the sticky error flag
    always_ff @(posedge jstkclk or posedge jstkreset) begin
        if (jstkreset) begin
            jstkled  <= 2'b00;
            posx     <= 10'd0;
            posy     <= 10'd0;
            buttons  <= 3'b000;
            dir      <= 4'b0000;
            btnpress <= 3'b000;
            davpoll  <= 1'b0;
            pollerr  <= 1'b0;
        end else begin
            if (start) begin
                jstkled <= ledreq;
            end
            if (capture) begin
                posx     <= jstkxdata;
                posy     <= jstkydata;
                buttons  <= jstkbutton;
                dir      <= dir_new;
                btnpress <= jstkbutton & ~buttons;
            end else begin
                btnpress <= 3'b000;
            end
            davpoll <= capture;
            if (expire) begin
                pollerr <= 1'b1;
            end else if (errclr) begin
                pollerr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jstkpoll.sv
module tb_jstkpoll;

    localparam int POLLDIV  = 16;
    localparam int TIMEOUT  = 32;
    localparam int CENTER   = 512;
    localparam int DEADZONE = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       pollen;
    logic [1:0] ledreq;
    logic       errclr;
    logic       jstkdav;
    logic [1:0] jstkled;
    logic       davjstk;
    logic [9:0] jstkxdata;
    logic [9:0] jstkydata;
    logic [2:0] jstkbutton;
    logic [9:0] posx;
    logic [9:0] posy;
    logic [2:0] buttons;
    logic [3:0] dir;
    logic [2:0] btnpress;
    logic       davpoll;
    logic       pollerr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
        logic [3:0] d;
        logic [2:0] p;
    } sample_t;

    sample_t    exp_q[$];
    logic [2:0] model_btn = 3'b000;
    logic [9:0] model_x   = 10'd0;
    bit         prev_dav  = 1'b0;

    jstkpoll #(
        .POLLDIV  (POLLDIV),
        .TIMEOUT  (TIMEOUT),
        .CENTER   (CENTER),
        .DEADZONE (DEADZONE)
    ) dut (
        .jstkclk    (clk),
        .jstkreset  (rst),
        .pollen     (pollen),
        .ledreq     (ledreq),
        .errclr     (errclr),
        .jstkdav    (jstkdav),
        .jstkled    (jstkled),
        .davjstk    (davjstk),
        .jstkxdata  (jstkxdata),
        .jstkydata  (jstkydata),
        .jstkbutton (jstkbutton),
        .posx       (posx),
        .posy       (posy),
        .buttons    (buttons),
        .dir        (dir),
        .btnpress   (btnpress),
        .davpoll    (davpoll),
        .pollerr    (pollerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: direction and press pulses straight from the rules
    function automatic sample_t model(input int x, input int y, input logic [2:0] b);
        sample_t s;
        s.x = 10'(x);
        s.y = 10'(y);
        s.b = b;
        s.d = {4{1'b0}};
        if (y > CENTER + DEADZONE) s.d[3] = 1'b1;
        if (y < CENTER - DEADZONE) s.d[2] = 1'b1;
        if (x < CENTER - DEADZONE) s.d[1] = 1'b1;
        if (x > CENTER + DEADZONE) s.d[0] = 1'b1;
        s.p = b & ~model_btn;
        model_btn = b;
        model_x   = 10'(x);
        return s;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        sample_t e;
        if (rst) begin
            prev_dav = 1'b0;
        end else begin
            if (davpoll) begin
                chk("davpoll_width", {31'd0, prev_dav}, 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_davpoll: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("posx", posx, e.x);
                    chk("posy", posy, e.y);
                    chk("buttons", buttons, e.b);
                    chk("dir", dir, e.d);
                    chk("btnpress", btnpress, e.p);
                end
            end else begin
                chk("btnpress_idle", btnpress, 0);
            end
            prev_dav = davpoll;
        end
    end

    // Wait for jstkdav to rise; n = posedges waited, -1 on timeout
    task automatic wait_req(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (jstkdav) begin
                n = i;
                break;
            end
        end
    endtask

    // Count posedges until jstkdav falls, -1 on timeout
    task automatic wait_fall(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (!jstkdav) begin
                n = i;
                break;
            end
        end
    endtask

    // Joystick model: answer delay cycles after REQ was first observed
    task automatic respond(input int delay, input int x, input int y, input logic [2:0] b);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        jstkxdata  = 10'(x);
        jstkydata  = 10'(y);
        jstkbutton = b;
        davjstk    = 1'b1;
        exp_q.push_back(model(x, y, b));
        @(posedge clk);
        #1;
        davjstk = 1'b0;
        chk("jstkdav_after_capture", jstkdav, 0);
    endtask

    task automatic poll(input int gap, input int delay, input int x, input int y, input logic [2:0] b);
        int n;
        wait_req(n);
        chk("req_gap", n, gap);
        chk("jstkled", jstkled, ledreq);
        respond(delay, x, y, b);
    endtask

    function automatic int pick_axis();
        int edges[6] = '{447, 448, 449, 575, 576, 577};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom_range(0, 1023);
    endfunction

    initial begin
        int n;
        bit seen;
        rst        = 1'b1;
        pollen     = 1'b1;
        ledreq     = 2'b10;
        errclr     = 1'b0;
        davjstk    = 1'b0;
        jstkxdata  = 10'd0;
        jstkydata  = 10'd0;
        jstkbutton = 3'b000;
        #2;
        chk("rst_jstkdav", jstkdav, 0);
        chk("rst_jstkled", jstkled, 0);
        chk("rst_posx", posx, 0);
        chk("rst_davpoll", davpoll, 0);
        chk("rst_pollerr", pollerr, 0);
        chk("rst_dir", dir, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal poll
        poll(16, 10, 700, 300, 3'b001);
        // Deadzone boundaries
        poll(16, 3, 576, 448, 3'b000);
        poll(16, 3, 577, 447, 3'b000);
        // Button edges
        poll(16, 2, 512, 512, 3'b011);
        poll(16, 2, 512, 512, 3'b011);
        poll(16, 2, 512, 512, 3'b110);

        // davjstk while idle is ignored (consumes one idle cycle)
        jstkxdata  = 10'd100;
        jstkbutton = 3'b111;
        davjstk    = 1'b1;
        @(posedge clk);
        #1;
        davjstk = 1'b0;
        chk("idle_dav_posx", posx, model_x);

        // Timeout with errclr held: set wins
        wait_req(n);
        chk("req_gap_after_idle_dav", n, 15);
        errclr = 1'b1;
        wait_fall(n);
        chk("timeout_len", n, TIMEOUT);
        chk("pollerr_set_wins", pollerr, 1);
        chk("timeout_posx", posx, model_x);
        errclr = 1'b0;
        @(posedge clk);
        #1;
        chk("pollerr_sticky", pollerr, 1);
        errclr = 1'b1;
        @(posedge clk);
        #1;
        errclr = 1'b0;
        chk("pollerr_cleared", pollerr, 0);
        // Strobe on the last timeout cycle wins
        wait_req(n);
        chk("req_gap_after_timeout", n, 14);
        respond(TIMEOUT - 1, 300, 800, 3'b101);
        chk("pollerr_after_late_dav", pollerr, 0);

        // pollen dropped mid-REQ
        wait_req(n);
        chk("req_gap", n, 16);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        pollen = 1'b0;
        respond(6, 40, 1000, 3'b010);
        seen = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (jstkdav) seen = 1'b1;
        end
        chk("no_req_pollen_off", {31'd0, seen}, 0);
        pollen = 1'b1;
        poll(16, 2, 512, 900, 3'b000);

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            ledreq = 2'($urandom_range(0, 3));
            poll(16, $urandom_range(0, 25), pick_axis(), pick_axis(), 3'($urandom_range(0, 7)));
        end

        // Reset mid-REQ
        wait_req(n);
        chk("req_gap", n, 16);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_jstkdav", jstkdav, 0);
        chk("midrst_jstkled", jstkled, 0);
        chk("midrst_posx", posx, 0);
        chk("midrst_posy", posy, 0);
        chk("midrst_buttons", buttons, 0);
        chk("midrst_dir", dir, 0);
        model_btn = 3'b000;
        model_x   = 10'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        poll(16, 4, 100, 100, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
        $finish;
    end

endmodule
